// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FETCH_WAIT = 2'd1,
        DATA_WAIT  = 2'd2
    } arb_state_t;

endpackage : mem_arb_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
    parameter int unsigned W   = 4,
    parameter int unsigned MAX = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != W'(MAX))) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule : sat_counter

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and data access,
// with data priority, a fetch-fairness burst limit and an access timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N           = 64,
    parameter int unsigned MAX_D_BURST = 4,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               if_req,
    input  logic [N-1:0]       if_addr,
    output logic [INSTR_W-1:0] if_rdata,
    output logic               if_done,
    output logic               if_stall,
    input  logic               dm_req,
    input  logic               dm_we,
    input  logic [N-1:0]       dm_addr,
    input  logic [N-1:0]       dm_wdata,
    output logic [N-1:0]       dm_rdata,
    output logic               dm_done,
    output logic               dm_stall,
    output logic               mem_req,
    output logic               mem_we,
    output logic [N-1:0]       mem_addr,
    output logic [N-1:0]       mem_wdata,
    input  logic [N-1:0]       mem_rdata,
    input  logic               mem_ack,
    output logic               err
);

    localparam int unsigned BURST_W = $clog2(MAX_D_BURST + 1);
    localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);

    arb_state_t         state_q;
    arb_state_t         state_d;
    logic               mem_req_d;
    logic               mem_we_d;
    logic [N-1:0]       mem_addr_d;
    logic [N-1:0]       mem_wdata_d;
    logic [INSTR_W-1:0] if_rdata_d;
    logic               if_done_d;
    logic [N-1:0]       dm_rdata_d;
    logic               dm_done_d;
    logic               err_d;

    logic               burst_inc_c;
    logic               burst_clr_c;
    logic               tmo_inc_c;
    logic               tmo_clr_c;
    logic               tmo_hit_c;
    logic               data_win_c;
    logic [BURST_W-1:0] burst_cnt;
    logic [TMO_W-1:0]   tmo_cnt;

    assign if_stall = if_req && !if_done;
    assign dm_stall = dm_req && !dm_done;

    // Data grants made while fetch is waiting; at the limit fetch takes the next grant.
    sat_counter #(
        .W   (BURST_W),
        .MAX (MAX_D_BURST)
    ) u_burst_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr   (burst_clr_c),
        .inc   (burst_inc_c),
        .cnt   (burst_cnt)
    );

    // Cycles spent waiting for mem_ack on the current access.
    sat_counter #(
        .W   (TMO_W),
        .MAX (TIMEOUT)
    ) u_tmo_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clr   (tmo_clr_c),
        .inc   (tmo_inc_c),
        .cnt   (tmo_cnt)
    );

    // This wait cycle brings the count to TIMEOUT, so the access is abandoned at this edge.
    assign tmo_hit_c  = (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign data_win_c = dm_req && (!if_req || (burst_cnt < BURST_W'(MAX_D_BURST)));

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if_rdata_d  = if_rdata;
        if_done_d   = 1'b0;
        dm_rdata_d  = dm_rdata;
        dm_done_d   = 1'b0;
        err_d       = err;
        burst_inc_c = 1'b0;
        burst_clr_c = 1'b0;
        tmo_inc_c   = 1'b0;
        tmo_clr_c   = 1'b1;

        unique case (state_q)
            IDLE: begin
                // The cycle presenting a done pulse never issues a new grant.
                if (!if_done && !dm_done) begin
                    if (data_win_c) begin
                        state_d     = DATA_WAIT;
                        mem_req_d   = 1'b1;
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        burst_inc_c = if_req;
                        burst_clr_c = !if_req;
                    end else if (if_req) begin
                        state_d     = FETCH_WAIT;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        burst_clr_c = 1'b1;
                    end
                end
            end

            FETCH_WAIT, DATA_WAIT: begin
                tmo_clr_c = 1'b0;
                tmo_inc_c = 1'b1;
                if (mem_ack || tmo_hit_c) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    tmo_clr_c = 1'b1;
                    if (!mem_ack) begin
                        err_d = 1'b1;
                    end
                    if (state_q == FETCH_WAIT) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_ack ? mem_rdata[INSTR_W-1:0] : '0;
                    end else begin
                        dm_done_d  = 1'b1;
                        dm_rdata_d = mem_ack ? mem_rdata : '0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            if_done   <= 1'b0;
            dm_rdata  <= '0;
            dm_done   <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            if_rdata  <= if_rdata_d;
            if_done   <= if_done_d;
            dm_rdata  <= dm_rdata_d;
            dm_done   <= dm_done_d;
            err       <= err_d;
        end
    end

endmodule : mem_port_arbiter
